muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//   Iterative multiply/divide unit with its sequencing controller for the RV64 M-extension.
//   Accepts the EX-stage muldiv request (operands, sign flags, op class) and runs a 1-bit/cycle
//   shift-add multiply or restoring divide. Stalls the pipeline until the result is ready.
//   Returns result_l/result_h to the EX-stage muldiv result inputs.
// PARAMETERS
//   XLEN   64   operand width; counter width is $clog2(XLEN)+1
// PORTS
//   clk             in   1      clock, rising edge
//   rst             in   1      reset, asynchronous, active-high
//   req_valid_i     in   1      muldiv instruction present in EX; held high while stall_o=1
//   op_div_i        in   1      0=MUL/MULH/MULHSU/MULHU, 1=DIV/DIVU/REM/REMU (funct3[2])
//   rs1_data_i      in   XLEN   multiplicand / dividend (forwarded value)
//   rs2_data_i      in   XLEN   multiplier / divisor (forwarded value)
//   rs1_sign_i      in   1      1 = treat rs1 as signed
//   rs2_sign_i      in   1      1 = treat rs2 as signed
//   flush_i         in   1      pipeline flush; abort the operation in flight
//   stall_o         out  1      hold PC/IF/ID/EX registers
//   busy_o          out  1      state != IDLE
//   result_valid_o  out  1      result_l_o/result_h_o valid this cycle (DONE)
//   result_l_o      out  XLEN   MUL: product[XLEN-1:0]; DIV: quotient
//   result_h_o      out  XLEN   MUL: product[2*XLEN-1:XLEN]; DIV: remainder
// BEHAVIOUR
//   Reset: state=IDLE, count=0; all outputs 0; internal acc/operand registers 0.
//   States: IDLE -> CALC -> FIX -> DONE -> IDLE; IDLE -> DONE for special divides.
//   IDLE: on req_valid_i & !flush_i, accept (cycle 0):
//     - latch |rs1|, |rs2|; a negative operand is negated only when its sign flag = 1.
//     - latch neg_res:
//       - MUL: sgn1^sgn2.
//       - DIV: quotient sign sgn1^sgn2; remainder sign sgn1.
//     - count=XLEN; next state CALC.
//   Special divides resolve at accept and go IDLE->DONE (result_valid_o in cycle 1):
//     - divisor==0: quotient = all-ones; remainder = rs1_data_i.
//     - signed, rs1=-2^(XLEN-1), rs2=-1: quotient = rs1_data_i; remainder = 0.
//   CALC: one iteration per cycle, count decrements; exits to FIX when count reaches 0
//     (XLEN cycles, cycles 1..XLEN).
//     - MUL: 2*XLEN-bit acc; add multiplicand when LSB of multiplier is 1; shift right.
//     - DIV: restoring; shift {rem,quo} left 1; subtract divisor if rem>=divisor; set quo bit.
//   FIX (cycle XLEN+1): two's-complement negation applied per neg_res, modulo 2^(2*XLEN) for
//     MUL and per-field for DIV; results registered into result_l_o/result_h_o.
//   DONE (cycle XLEN+2): result_valid_o=1, stall_o=0 so EX retires; next state IDLE.
//   Registered results hold their values until the next accept.
//   stall_o = req_valid_i & !result_valid_o & !flush_i (combinational).
//     - Asserted in the accept cycle and through CALC/FIX.
//   A request present in the cycle after DONE is a new instruction and is accepted normally.
//   flush_i has priority in every state:
//     - next state IDLE; no result_valid_o pulse; result registers unchanged.
//     - flush_i and req_valid_i together in IDLE: not accepted.
//   req_valid_i dropping mid-operation without flush_i: the operation completes; the result is
//     discarded by EX.
//   Asynchronous reset mid-operation: immediate return to the reset state; no result pulse.
//   MULHSU: rs1 signed, rs2 unsigned; sign flags come from EX, not decoded here.
//   Word (*W) ops: out of scope; EX presents sign-extended operands.
// TESTING
//   MUL 3 x -5 (signed/signed) -> result_valid_o at cycle 66 after accept; l=0xFFFF_FFFF_FFFF_FFF1, h=all-ones; stall_o high cycles 0..65.
//   MULHU 0xFFFF_FFFF_FFFF_FFFF x same -> h=0xFFFF_FFFF_FFFF_FFFE, l=1.
//   MULHSU rs1=-1, rs2=2 -> h=all-ones, l=0xFFFF_FFFF_FFFF_FFFE.
//   DIV -7 / 2 -> q=-3 (0xFFFF_FFFF_FFFF_FFFD), r=-1; DIVU 100/7 -> q=14, r=2.
//   Specials: DIVU 5/0 -> q=all-ones, r=5, valid at cycle 1; DIV 0x8000_0000_0000_0000/-1 -> q=0x8000_0000_0000_0000, r=0, valid at cycle 1.
//   Flush/reset: flush_i at cycle 10 of CALC -> IDLE next cycle, no result_valid_o, previous results retained; next request accepted and completes correctly; async rst mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> iterative multiply/divide unit request/result bundle.
// The master side is the EX stage; the slave side is muldiv_ctrl.
interface muldiv_ctrl_if #(
  parameter int XLEN = 64
);
  logic            req_valid_i;
  logic            op_div_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic            rs1_sign_i;
  logic            rs2_sign_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_l_o;
  logic [XLEN-1:0] result_h_o;

  modport master (
    output req_valid_i, op_div_i, rs1_data_i, rs2_data_i, rs1_sign_i, rs2_sign_i, flush_i,
    input  stall_o, busy_o, result_valid_o, result_l_o, result_h_o
  );

  modport slave (
    input  req_valid_i, op_div_i, rs1_data_i, rs2_data_i, rs1_sign_i, rs2_sign_i, flush_i,
    output stall_o, busy_o, result_valid_o, result_l_o, result_h_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV64 M-extension iterative multiplier/divider: 1 bit per cycle shift-add multiply
// and restoring divide on operand magnitudes, with sign fix-up and pipeline stall control.
module muldiv_ctrl #(
  parameter int XLEN = 64
) (
  input logic          clk,
  input logic          rst,
  muldiv_ctrl_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   operand;
  logic              op_div;
  logic              neg_lo;
  logic              neg_hi;
  logic [XLEN-1:0]   res_l;
  logic [XLEN-1:0]   res_h;

  logic              sgn1, sgn2;
  logic [XLEN-1:0]   abs1, abs2;
  logic              accept, div_zero, div_ovf, special;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign sgn1     = bus.rs1_sign_i & bus.rs1_data_i[XLEN-1];
  assign sgn2     = bus.rs2_sign_i & bus.rs2_data_i[XLEN-1];
  assign abs1     = sgn1 ? -bus.rs1_data_i : bus.rs1_data_i;
  assign abs2     = sgn2 ? -bus.rs2_data_i : bus.rs2_data_i;
  assign accept   = (state == IDLE) & bus.req_valid_i & ~bus.flush_i;
  assign div_zero = (bus.rs2_data_i == '0);
  assign div_ovf  = bus.rs1_sign_i & bus.rs2_sign_i & (bus.rs2_data_i == '1)
                  & (bus.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}});
  assign special  = bus.op_div_i & (div_zero | div_ovf);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right with carry.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}; a borrow means the divisor did not fit.
  assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, operand};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (count == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush_i) state_next = IDLE;
  end

  // A flush must leave the previously registered results untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      acc     <= '0;
      operand <= '0;
      op_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      res_l   <= '0;
      res_h   <= '0;
    end else if (accept) begin
      count   <= CW'(XLEN);
      op_div  <= bus.op_div_i;
      neg_lo  <= sgn1 ^ sgn2;
      neg_hi  <= sgn1;
      operand <= bus.op_div_i ? abs2 : abs1;
      acc     <= {{XLEN{1'b0}}, (bus.op_div_i ? abs1 : abs2)};
      if (special) begin
        res_l <= div_zero ? '1 : bus.rs1_data_i;
        res_h <= div_zero ? bus.rs1_data_i : '0;
      end
    end else if (!bus.flush_i) begin
      if (state == CALC) begin
        count <= count - CW'(1);
        acc   <= op_div ? div_next : mul_next;
      end else if (state == FIX) begin
        if (op_div) begin
          res_l <= neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
          res_h <= neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        end else begin
          {res_h, res_l} <= neg_lo ? -acc : acc;
        end
      end
    end
  end

  assign bus.busy_o         = (state != IDLE);
  assign bus.result_valid_o = (state == DONE) & ~bus.flush_i;
  assign bus.stall_o        = bus.req_valid_i & ~bus.result_valid_o & ~bus.flush_i & ~rst;
  assign bus.result_l_o     = res_l;
  assign bus.result_h_o     = res_h;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the driver pushes model results, a monitor pops
// and compares them whenever result_valid_o is seen.
module tb_muldiv_ctrl;
  localparam int XLEN = 64;

  typedef struct {
    logic [63:0] l;
    logic [63:0] h;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   acceptCyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic [63:0] lastL = '0;
  logic [63:0] lastH = '0;
  exp_t expQ[$];

  muldiv_ctrl_if #(.XLEN(XLEN)) bus ();

  muldiv_ctrl #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Reference: exact wide arithmetic on sign/zero-extended operands, RISC-V special cases.
  function automatic exp_t modelOp(input logic div, input logic [63:0] a, input logic [63:0] b,
                                   input logic s1, input logic s2);
    exp_t e;
    logic signed [129:0] x, y, p, q, r;
    x = s1 ? {{66{a[63]}}, a} : {66'b0, a};
    y = s2 ? {{66{b[63]}}, b} : {66'b0, b};
    e.lat = 66;
    if (!div) begin
      p   = x * y;
      e.l = p[63:0];
      e.h = p[127:64];
    end else if (b == 64'd0) begin
      e.l   = '1;
      e.h   = a;
      e.lat = 1;
    end else begin
      q   = x / y;
      r   = x % y;
      e.l = q[63:0];
      e.h = r[63:0];
      if (s1 && s2 && (q > 130'sd9223372036854775807)) e.lat = 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.result_valid_o) begin
      exp_t e;
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_valid: got result_valid_o=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = expQ.pop_front();
        checkOutput("result_l", bus.result_l_o, e.l);
        checkOutput("result_h", bus.result_h_o, e.h);
        checkOutput("latency", 64'(cyc - acceptCyc), 64'(e.lat));
        lastL = e.l;
        lastH = e.h;
      end
    end
  end

  task automatic applyStimulus(input logic div, input logic [63:0] a, input logic [63:0] b,
                               input logic s1, input logic s2);
    exp_t e;
    int   stallCycles = 0;
    bit   seen = 0;
    e = modelOp(div, a, b, s1, s2);
    bus.req_valid_i = 1'b1;
    bus.op_div_i    = div;
    bus.rs1_data_i  = a;
    bus.rs2_data_i  = b;
    bus.rs1_sign_i  = s1;
    bus.rs2_sign_i  = s2;
    acceptCyc       = cyc;
    expQ.push_back(e);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.stall_o) stallCycles++;
      if (bus.result_valid_o) seen = 1;
    end
    if (!seen) begin
      checks++;
      $display("[TB] FAIL timeout: got no result_valid_o expected one within 200 cycles");
      if (expQ.size() > 0) void'(expQ.pop_back());
    end
    checkOutput("stall_cycles", 64'(stallCycles), 64'(e.lat));
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.req_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
  endtask

  initial begin
    logic [63:0] a, b;
    logic        div, s1, s2;
    int          pick;

    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.op_div_i    = 1'b0;
    bus.rs1_data_i  = '0;
    bus.rs2_data_i  = '0;
    bus.rs1_sign_i  = 1'b0;
    bus.rs2_sign_i  = 1'b0;
    bus.flush_i     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("reset_valid", 64'(bus.result_valid_o), 64'd0);
    checkOutput("reset_result_l", bus.result_l_o, 64'd0);
    checkOutput("reset_result_h", bus.result_h_o, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases, issued back-to-back.
    applyStimulus(1'b0, 64'd3, -64'sd5, 1'b1, 1'b1);
    applyStimulus(1'b0, '1, '1, 1'b0, 1'b0);
    applyStimulus(1'b0, '1, 64'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, -64'sd7, 64'd2, 1'b1, 1'b1);
    applyStimulus(1'b1, 64'd100, 64'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd5, 64'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h8000_0000_0000_0000, '1, 1'b1, 1'b1);
    applyStimulus(1'b1, -64'sd9, 64'd0, 1'b1, 1'b1);
    idleInputs();
    @(posedge clk);
    #1;

    // Flush ten cycles into CALC: no result, previous result retained.
    bus.req_valid_i = 1'b1;
    bus.op_div_i    = 1'b0;
    bus.rs1_data_i  = 64'd12345;
    bus.rs2_data_i  = 64'd678;
    bus.rs1_sign_i  = 1'b0;
    bus.rs2_sign_i  = 1'b0;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1 idleInputs();
    @(negedge clk);
    checkOutput("flush_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("flush_keep_l", bus.result_l_o, lastL);
    checkOutput("flush_keep_h", bus.result_h_o, lastH);
    repeat (70) @(negedge clk);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 64'd1000, 64'd33, 1'b0, 1'b0);

    // Random mix; DIV uses matched sign flags, MUL also covers MULHSU.
    for (int n = 0; n < 20; n++) begin
      div  = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 3);
      a    = {$urandom, $urandom};
      b    = (pick == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
      if (pick == 1) a = 64'($urandom) - 64'd2147483648;
      s1   = 1'($urandom_range(0, 1));
      s2   = div ? s1 : (s1 & 1'($urandom_range(0, 1)));
      applyStimulus(div, a, b, s1, s2);
    end
    idleInputs();
    @(posedge clk);
    #1;

    // Asynchronous reset mid-CALC clears everything at once.
    bus.req_valid_i = 1'b1;
    bus.op_div_i    = 1'b1;
    bus.rs1_data_i  = 64'd999;
    bus.rs2_data_i  = 64'd10;
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("arst_stall", 64'(bus.stall_o), 64'd0);
    checkOutput("arst_result_l", bus.result_l_o, 64'd0);
    checkOutput("arst_result_h", bus.result_h_o, 64'd0);
    idleInputs();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, -64'sd4, -64'sd6, 1'b1, 1'b1);
    idleInputs();
    repeat (3) @(posedge clk);

    if (expQ.size() != 0) begin
      checks++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
